// File: rtl/pp_arb_pkg.sv
// Shared types and constants for the ping-pong buffer write-side arbiter.
// Word layout: [1:0] sample count, followed by three 10-bit slots.
package pp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2
  } arb_state_e;

  localparam int SAMPLE_W  = 10;
  localparam int CNT_W     = 2;
  localparam int SLOT0_OFF = 2;
  localparam int SLOT1_OFF = 12;
  localparam int SLOT2_OFF = 22;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request bit at or above
// rr_ptr, wrapping past the top requester back to requester 0.
module rr_pick #(
  parameter int REQ_NUM = 2,
  parameter int IDX_W   = 2
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [REQ_NUM-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int pos_s;

  // Scan REQ_NUM positions starting at rr_ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos_s = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      pos_s = (int'(rr_ptr) + k) % REQ_NUM;
      if (!found && req[pos_s]) begin
        found      = 1'b1;
        gnt[pos_s] = 1'b1;
        idx        = IDX_W'(pos_s);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/pp_wr_arbiter.sv
// Round-robin arbiter packing 10-bit samples from up to four producers into
// 32-bit count+payload words for a ping-pong buffer write port.
// Optional idle-timeout flush/release enabled by PP_WR_ARB_TIMEOUT_EN.
module pp_wr_arbiter
  import pp_arb_pkg::*;
#(
  parameter int REQ_NUM       = 2,
  parameter int PACK_NUM      = 3,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [REQ_NUM-1:0]          Req_valid,
  output logic [REQ_NUM-1:0]          Req_ready,
  input  logic [REQ_NUM*SAMPLE_W-1:0] Req_data,
  input  logic [REQ_NUM-1:0]          Req_last,
  output logic                        Wr_valid,
  input  logic                        Wr_ready,
  output logic [31:0]                 Wr_data,
  output logic [1:0]                  Wr_src,
  output logic [REQ_NUM-1:0]          Grant
);

  arb_state_e           state_r, state_s;
  logic [REQ_NUM-1:0]   grant_r, grant_s;
  logic [1:0]           src_r, src_s;
  logic [1:0]           rr_ptr_r, rr_ptr_s;
  logic [31:0]          word_r, word_s;
  logic                 end_pkt_r, end_pkt_s;
  logic [REQ_NUM-1:0]   ready_r;
  logic                 wr_valid_r;
  logic [REQ_NUM-1:0]   pick_gnt_s;
  logic [1:0]           pick_idx_s;
  logic                 pick_found_s;
  logic [SAMPLE_W-1:0]  sample_s;
  logic                 last_s;
  logic                 beat_s;
  logic [CNT_W-1:0]     cnt_s;
  logic [1:0]           next_ptr_s;

`ifdef PP_WR_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(FLUSH_TIMEOUT);
  logic [7:0] idle_r, idle_s;
`endif

  rr_pick #(.REQ_NUM(REQ_NUM), .IDX_W(2)) u_rr_pick (
    .req    (Req_valid),
    .rr_ptr (rr_ptr_r),
    .gnt    (pick_gnt_s),
    .idx    (pick_idx_s),
    .found  (pick_found_s)
  );

  // Select the granted requester's sample and last flag.
  always_comb begin
    sample_s = '0;
    last_s   = 1'b0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (grant_r[k]) begin
        sample_s = Req_data[k*SAMPLE_W +: SAMPLE_W];
        last_s   = Req_last[k];
      end else begin
        last_s = last_s;
      end
    end
  end

  assign beat_s     = (state_r == ST_COLLECT) && (|(Req_valid & grant_r));
  assign cnt_s      = word_r[CNT_W-1:0];
  assign next_ptr_s = (src_r == 2'(REQ_NUM - 1)) ? 2'd0 : (src_r + 2'd1);

  // Next-state, packing and grant bookkeeping.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    src_s     = src_r;
    rr_ptr_s  = rr_ptr_r;
    word_s    = word_r;
    end_pkt_s = end_pkt_r;
`ifdef PP_WR_ARB_TIMEOUT_EN
    idle_s    = 8'd0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_s   = pick_gnt_s;
          src_s     = pick_idx_s;
          word_s    = 32'd0;
          end_pkt_s = 1'b0;
          state_s   = ST_COLLECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (beat_s) begin
          case (cnt_s)
            2'd0:    word_s[SLOT0_OFF +: SAMPLE_W] = sample_s;
            2'd1:    word_s[SLOT1_OFF +: SAMPLE_W] = sample_s;
            2'd2:    word_s[SLOT2_OFF +: SAMPLE_W] = sample_s;
            default: word_s = word_r;
          endcase
          word_s[CNT_W-1:0] = cnt_s + 2'd1;
          if (last_s) begin
            end_pkt_s = 1'b1;
            state_s   = ST_SEND;
          end else if (({1'b0, cnt_s} + 3'd1) == 3'(PACK_NUM)) begin
            state_s = ST_SEND;
          end else begin
            state_s = ST_COLLECT;
          end
        end else begin
`ifdef PP_WR_ARB_TIMEOUT_EN
          // A silent owner either gets its partial word flushed or loses the grant.
          if ((idle_r + 8'd1) == TIMEOUT_LIMIT) begin
            if (cnt_s != 2'd0) begin
              state_s = ST_SEND;
            end else begin
              grant_s  = '0;
              rr_ptr_s = next_ptr_s;
              state_s  = ST_IDLE;
            end
          end else begin
            idle_s = idle_r + 8'd1;
          end
`else
          state_s = ST_COLLECT;
`endif
        end
      end
      ST_SEND: begin
        if (Wr_ready) begin
          word_s = 32'd0;
          if (end_pkt_r) begin
            rr_ptr_s  = next_ptr_s;
            grant_s   = '0;
            end_pkt_s = 1'b0;
            state_s   = ST_IDLE;
          end else begin
            state_s = ST_COLLECT;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        grant_s   = '0;
        word_s    = 32'd0;
        end_pkt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; outputs are derived from the next state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      src_r      <= 2'd0;
      rr_ptr_r   <= 2'd0;
      word_r     <= 32'd0;
      end_pkt_r  <= 1'b0;
      ready_r    <= '0;
      wr_valid_r <= 1'b0;
`ifdef PP_WR_ARB_TIMEOUT_EN
      idle_r     <= 8'd0;
`endif
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      src_r      <= src_s;
      rr_ptr_r   <= rr_ptr_s;
      word_r     <= word_s;
      end_pkt_r  <= end_pkt_s;
      ready_r    <= (state_s == ST_COLLECT) ? grant_s : '0;
      wr_valid_r <= (state_s == ST_SEND);
`ifdef PP_WR_ARB_TIMEOUT_EN
      idle_r     <= idle_s;
`endif
    end
  end

  assign Req_ready = ready_r;
  assign Wr_valid  = wr_valid_r;
  assign Wr_data   = word_r;
  assign Wr_src    = src_r;
  assign Grant     = grant_r;

endmodule

// File: tb/tb_pp_wr_arbiter.sv
// Self-checking bench for pp_wr_arbiter: directed cases with literal
// expectations plus randomized packets checked against a queue-based model.
module tb_pp_wr_arbiter;

  localparam int N  = 2;
  localparam int P  = 3;
  localparam int FT = 16;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [N-1:0]    Req_valid, Req_ready, Req_last, Grant;
  logic [N*10-1:0] Req_data;
  logic            Wr_valid, Wr_ready;
  logic [31:0]     Wr_data;
  logic [1:0]      Wr_src;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner index (-1 = nobody), collected samples, send flag.
  int  m_owner = -1;
  int  m_rr    = 0;
  int  m_samp[$];
  bit  m_send  = 1'b0;
  bit  m_end   = 1'b0;
  int  m_idle  = 0;

  logic [31:0] acc_w[$];
  int          acc_s[$];

  always #5 Clk = ~Clk;

  pp_wr_arbiter #(.REQ_NUM(N), .PACK_NUM(P), .FLUSH_TIMEOUT(FT)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_data(Req_data), .Req_last(Req_last),
    .Wr_valid(Wr_valid), .Wr_ready(Wr_ready), .Wr_data(Wr_data), .Wr_src(Wr_src),
    .Grant(Grant)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Compare DUT against model every cycle, then advance the model by the
  // inputs that the next rising edge will sample.
  always @(negedge Clk) begin
    logic [31:0] eg, ew;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("grant", 32'(Grant), eg);
    chk("req_ready", 32'(Req_ready), (m_owner >= 0 && !m_send) ? eg : 32'd0);
    chk("wr_valid", 32'(Wr_valid), 32'(m_send));
    if (m_send) begin
      ew = 32'(m_samp.size());
      for (int i = 0; i < m_samp.size(); i++) ew = ew | (32'(m_samp[i]) << (2 + 10 * i));
      chk("wr_data", Wr_data, ew);
      chk("wr_src", 32'(Wr_src), 32'(m_owner));
    end
    if (Wr_valid && Wr_ready && !Rst) begin
      acc_w.push_back(Wr_data);
      acc_s.push_back(int'(Wr_src));
    end

    if (Rst) begin
      m_owner = -1; m_rr = 0; m_samp.delete(); m_send = 1'b0; m_end = 1'b0; m_idle = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && Req_valid[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
      end
      m_idle = 0;
    end else if (m_send) begin
      if (Wr_ready) begin
        m_samp.delete();
        m_send = 1'b0;
        m_idle = 0;
        if (m_end) begin
          m_rr = (m_owner + 1) % N; m_owner = -1; m_end = 1'b0;
        end
      end
    end else begin
      if (Req_valid[m_owner]) begin
        m_samp.push_back(int'(Req_data[m_owner*10 +: 10]));
        m_idle = 0;
        if (Req_last[m_owner]) begin
          m_end = 1'b1; m_send = 1'b1;
        end else if (m_samp.size() == P) begin
          m_send = 1'b1;
        end
      end else begin
`ifdef PP_WR_ARB_TIMEOUT_EN
        m_idle++;
        if (m_idle == FT) begin
          m_idle = 0;
          if (m_samp.size() > 0) m_send = 1'b1;
          else begin
            m_rr = (m_owner + 1) % N; m_owner = -1;
          end
        end
`endif
      end
    end
  end

  task automatic send_beat(int r, logic [9:0] d, bit last);
    int  n;
    bit  ok;
    n = 0; ok = 1'b0;
    Req_valid[r] = 1'b1;
    Req_data[r*10 +: 10] = d;
    Req_last[r] = last;
    while (!ok && n < 200) begin
      @(negedge Clk);
      ok = Req_ready[r];
      n++;
    end
    if (!ok) timeout_fail("beat_accept");
    @(posedge Clk); #1;
    Req_valid[r] = 1'b0;
    Req_last[r]  = 1'b0;
  endtask

  task automatic wait_words(int target);
    int n;
    n = 0;
    while (acc_w.size() < target && n < 300) begin
      @(posedge Clk); #2;
      n++;
    end
    if (acc_w.size() < target) timeout_fail("word_wait");
  endtask

  initial begin
    int          base, got, cyc;
    int          srcs[$];
    int          left[N], pk[N], gap[N];
    logic [N-1:0] acc;
    bit          done;

    Rst = 1'b1; Req_valid = '0; Req_data = '0; Req_last = '0; Wr_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_wr_data", Wr_data, 32'd0);
    chk("rst_wr_src", 32'(Wr_src), 32'd0);
    chk("rst_grant", 32'(Grant), 32'd0);
    @(posedge Clk); #1;

    // Full word from requester 0
    base = acc_w.size();
    send_beat(0, 10'h001, 1'b0);
    send_beat(0, 10'h002, 1'b0);
    send_beat(0, 10'h003, 1'b1);
    wait_words(base + 1);
    if (acc_w.size() > base) begin
      chk("t1_word", acc_w[base], 32'h00C02007);
      chk("t1_src", 32'(acc_s[base]), 32'd0);
    end
    repeat (3) @(posedge Clk);
    #1 chk("t1_idle_grant", 32'(Grant), 32'd0);

    // Partial word from requester 1
    base = acc_w.size();
    send_beat(1, 10'h155, 1'b0);
    send_beat(1, 10'h2AA, 1'b1);
    wait_words(base + 1);
    if (acc_w.size() > base) begin
      chk("t2_word", acc_w[base], 32'h002AA556);
      chk("t2_src", 32'(acc_s[base]), 32'd1);
    end
    repeat (3) @(posedge Clk); #1;

    // Both requesters always valid with one-beat packets
    Req_data = {10'h0BB, 10'h0AA};
    Req_last = 2'b11;
    Req_valid = 2'b11;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 200) begin
      @(negedge Clk);
      if (Wr_valid && Wr_ready) begin
        got++;
        srcs.push_back(int'(Wr_src));
      end
      cyc++;
    end
    @(posedge Clk); #1;
    Req_valid = '0; Req_last = '0;
    if (got < 4) timeout_fail("t3_words");
    else begin
      chk("t3_src0", 32'(srcs[0]), 32'd0);
      chk("t3_src1", 32'(srcs[1]), 32'd1);
      chk("t3_src2", 32'(srcs[2]), 32'd0);
      chk("t3_src3", 32'(srcs[3]), 32'd1);
    end
    repeat (3) @(posedge Clk); #1;

    // Back-pressure during SEND
    Wr_ready = 1'b0;
    base = acc_w.size();
    send_beat(0, 10'h007, 1'b0);
    send_beat(0, 10'h008, 1'b0);
    send_beat(0, 10'h009, 1'b1);
    repeat (5) @(posedge Clk);
    #1 Wr_ready = 1'b1;
    wait_words(base + 1);
    repeat (5) @(posedge Clk); #1;
    chk("t4_once", 32'(acc_w.size() - base), 32'd1);
    if (acc_w.size() > base) chk("t4_word", acc_w[base], 32'h0240801F);

    // Reset with two samples pending
    base = acc_w.size();
    send_beat(1, 10'h111, 1'b0);
    send_beat(1, 10'h222, 1'b0);
    Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    chk("t5_wr_valid", 32'(Wr_valid), 32'd0);
    chk("t5_wr_data", Wr_data, 32'd0);
    chk("t5_ready", 32'(Req_ready), 32'd0);
    chk("t5_grant", 32'(Grant), 32'd0);
    repeat (20) @(posedge Clk); #1;
    chk("t5_no_word", 32'(acc_w.size() - base), 32'd0);

`ifdef PP_WR_ARB_TIMEOUT_EN
    // One beat then silence: partial flush, then grant release
    base = acc_w.size();
    send_beat(0, 10'h3FF, 1'b0);
    wait_words(base + 1);
    if (acc_w.size() > base) chk("t6_word", acc_w[base], 32'h00000FFD);
    repeat (FT + 4) @(posedge Clk);
    #1 chk("t6_release", 32'(Grant), 32'd0);
`endif

    // Randomized packets from all requesters with random back-pressure
    for (int r = 0; r < N; r++) begin
      pk[r] = 25; left[r] = 0; gap[r] = 0;
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 20000) begin
      @(negedge Clk);
      acc = Req_valid & Req_ready;
      @(posedge Clk); #1;
      cyc++;
      Wr_ready = ($urandom_range(3, 0) != 0);
      done = 1'b1;
      for (int r = 0; r < N; r++) begin
        if (acc[r]) begin
          Req_valid[r] = 1'b0;
          left[r]--;
          if (left[r] == 0) pk[r]--;
          gap[r] = ($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0;
        end
        if (!Req_valid[r]) begin
          if (gap[r] > 0) gap[r]--;
          else if (left[r] > 0 || pk[r] > 0) begin
            if (left[r] == 0) left[r] = $urandom_range(5, 1);
            Req_valid[r] = 1'b1;
            Req_data[r*10 +: 10] = 10'($urandom);
            Req_last[r] = (left[r] == 1);
          end
        end
        if (left[r] > 0 || pk[r] > 0) done = 1'b0;
      end
    end
    if (!done) timeout_fail("random_phase");
    Wr_ready = 1'b1;
    cyc = 0;
    while ((Grant != '0 || Wr_valid) && cyc < 100) begin
      @(posedge Clk); #1;
      cyc++;
    end
    if (cyc >= 100) timeout_fail("drain");
    repeat (2) @(posedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
